// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Memory-side responder for the core's native memory port. Accepts
//            a request, waits WAIT_CYCLES wait states, commits a word read or
//            a byte-strobed write to an internal single-port word array and
//            answers with a one-cycle mem_ready pulse.
// Ports    : clk        - clock, all state changes on the rising edge
//            reset      - asynchronous active-high reset
//            mem_valid  - request from core
//            mem_instr  - instruction fetch marker (informational only)
//            mem_addr   - byte address, bits [1:0] ignored
//            mem_wdata  - write data
//            mem_wstrb  - byte write enables, all zero means read
//            mem_ready  - one-cycle response strobe (registered)
//            mem_rdata  - read data, valid while mem_ready is high
//            fault      - out-of-range access, asserted with mem_ready
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        fault
);

    localparam int         c_AW       = $clog2(MEM_WORDS);
    localparam logic       c_NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0] c_CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_mem [MEM_WORDS];

    logic            w_accept;
    logic            w_commit;
    logic [31:0]     w_addr;
    logic [31:0]     w_wdata;
    logic [3:0]      w_wstrb;
    logic [c_AW-1:0] w_idx;
    logic            w_in_range;
    logic            w_unused;

    assign w_accept = (r_state == c_IDLE) && mem_valid;
    assign w_commit = (w_accept && c_NO_WAIT) || ((r_state == c_WAIT) && (r_cnt == 4'd0));

    // With zero wait states the commit happens on the accept edge, before the
    // request has been latched, so the live bus is used in IDLE.
    assign w_addr  = (r_state == c_IDLE) ? mem_addr  : r_addr;
    assign w_wdata = (r_state == c_IDLE) ? mem_wdata : r_wdata;
    assign w_wstrb = (r_state == c_IDLE) ? mem_wstrb : r_wstrb;

    assign w_idx      = w_addr[c_AW+1:2];
    // addr < 4*MEM_WORDS is equivalent to all bits above the index being zero
    assign w_in_range = (w_addr[31:c_AW+2] == '0);

    assign w_unused = &{1'b0, mem_instr, w_addr[1:0]};

    // Array write port. Gated by reset so a commit edge that coincides with
    // reset assertion never leaves a partial write behind.
    always_ff @(posedge clk) begin
        if (w_commit && w_in_range && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            fault     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (mem_valid) begin
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_wstrb <= mem_wstrb;
                        if (c_NO_WAIT) begin
                            r_state <= c_RESP;
                        end else begin
                            r_cnt   <= c_CNT_LOAD;
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    mem_ready <= 1'b0;
                    fault     <= 1'b0;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Response outputs are loaded on the commit edge; writes leave
            // mem_rdata holding its previous value.
            if (w_commit) begin
                mem_ready <= 1'b1;
                fault     <= !w_in_range;
                if (w_wstrb == 4'd0) begin
                    mem_rdata <= w_in_range ? r_mem[w_idx] : 32'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-side responder for the core's native memory port. It accepts `mem_valid` requests, serves word-aligned reads and byte-strobed writes from an internal single-port word array, inserts a programmable number of wait states, and answers with a one-cycle `mem_ready` pulse. It sits directly downstream of `riscv` and serves both instruction fetches and data accesses, which gives simulation and formal runs a real memory in place of a free `mem_rdata` input.

## Interface
- `MEM_WORDS`, 1024: depth of the word array, in 32-bit words; power of two, ≥ 2.
- `WAIT_CYCLES`, 1: wait states inserted between request acceptance and the memory commit; 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `mem_valid`  in  1  request from core.
- `mem_instr`  in  1  request is an instruction fetch; informational only, no effect on the access.
- `mem_addr`  in  32  byte address; bits [1:0] are ignored because all accesses are aligned.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte write enables; all zero means a read.
- `mem_ready`  out  1  one-cycle response strobe.
- `mem_rdata`  out  32  read data; valid while `mem_ready` is high.
- `fault`  out  1  asserted together with `mem_ready` when the address is out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE, `mem_valid`=1 at a rising edge: the request is accepted.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` are latched.
  - If `WAIT_CYCLES`=0, commit at this same edge and go to RESP.
  - Otherwise load `cnt` = `WAIT_CYCLES`-1 and go to WAIT.
- WAIT: if `cnt`=0, commit at this edge and go to RESP; otherwise decrement `cnt`.
- RESP: `mem_ready`=1 for exactly one cycle, then always go to IDLE. `mem_valid` is not examined in RESP.
- Commit, with index = latched addr[log2(MEM_WORDS)+1:2]:
  - In range means latched addr < 4·MEM_WORDS.
  - Read (wstrb=0), in range: `mem_rdata` <= word[index].
  - Write, in range: for each i with wstrb[i]=1, word[index][8i+7:8i] <= wdata[8i+7:8i]. Other bytes are unchanged, and `mem_rdata` holds its previous value.
  - Out of range: no array write; `mem_rdata` <= 0 for reads and holds for writes; `fault` <= 1.
- `fault` and `mem_ready` are both registered. Both clear at the next edge after RESP.
- The latched request is fixed once accepted. A change or drop of `mem_valid`, `mem_addr`, `mem_wdata` or `mem_wstrb` during WAIT or RESP has no effect, and the access still completes.
- Back-to-back requests: `mem_valid` high in the IDLE cycle that follows RESP is accepted as a new request. There is no combinational path from `mem_valid` to `mem_ready`.
- Memory contents are not cleared by reset; initial contents are undefined.

## Timing
- Reset values: state=IDLE, `cnt`=0, `mem_ready`=0, `mem_rdata`=0, `fault`=0. The latched request registers clear to 0.
- Reset asserted mid-operation, in WAIT or RESP before or at the commit edge:
  - The access is abandoned and no partial write occurs.
  - A write that was already committed stays in memory.
  - Outputs return to their reset values immediately.
- Latency:
  - With acceptance at edge t0, commit happens at edge t0+`WAIT_CYCLES`.
  - `mem_ready` is high between t0+`WAIT_CYCLES` and t0+`WAIT_CYCLES`+1, and the core samples it at edge t0+`WAIT_CYCLES`+1.
- Throughput: one access per `WAIT_CYCLES`+2 cycles at best, covering accept, wait states, RESP, and the re-accept edge in IDLE.
- `mem_ready` never stays high two consecutive cycles, and it is never high during reset.

## Test plan
- Reset and idle: hold `reset` for 3 cycles, then `mem_valid`=0 for 10 cycles. Required: `mem_ready`=0, `fault`=0 and `mem_rdata`=0 throughout.
- Write then read, `WAIT_CYCLES`=1:
  - Stimulus: write 0xDEADBEEF to 0x100 with wstrb=4'hF, then read 0x100.
  - Required: each `mem_ready` is sampled 2 edges after acceptance, and the read returns 0xDEADBEEF with `fault`=0.
- Byte strobes: write 0x11223344 to 0x20, then write 0xAABBCCDD with wstrb=4'b0101, then read 0x20. Required: 0x11BB33DD.
- Out of range, `MEM_WORDS`=1024:
  - Stimulus: read 0x1000; write 0x55 to 0x1000; then read 0x0.
  - Required: first response has `fault`=1 and `mem_rdata`=0; second response has `fault`=1; word 0 is unchanged.
- Wait-state sweep and fixed request: `WAIT_CYCLES` ∈ {0,3,15}, and drop `mem_valid` or change `mem_addr` during WAIT.
  - Required: exactly one `mem_ready` pulse at t0+`WAIT_CYCLES`+1 per request.
  - Required: the data comes from the originally latched address.
- Reset mid-write:
  - Stimulus: `WAIT_CYCLES`=4, write 0xCAFEF00D to 0x40 (previously 0), and assert `reset` asynchronously in WAIT with `cnt`=2.
  - Required: `mem_ready` never pulses, and a subsequent read of 0x40 returns 0.
